// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding, widths, default depth.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package mips_pkg;

  localparam int IMEM_WORD_W           = 32;
  localparam int IMEM_BYTE_W           = 8;
  localparam int IMEM_DEPTH_WORDS_DFLT = 1024;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN0 = 3'd1,
    ST_LEN1 = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } ldr_state_e;

  // True in the states that consume stream bytes.
  function automatic logic ldr_takes_bytes(input ldr_state_e s);
    return (s == ST_LEN0) || (s == ST_LEN1) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/loader_word_asm.sv
// Packs four little-endian stream bytes into one 32-bit instruction word.
// Latency: word_vld_o pulses one cycle after the 4th byte of a word is accepted.
// Backpressure: none of its own; it only advances on byte_acc_i from the owning FSM.
module loader_word_asm
  import mips_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   byte_acc_i,
  input  logic [IMEM_BYTE_W-1:0] byte_dat_i,
  output logic                   word_last_o,
  output logic                   word_vld_o,
  output logic [IMEM_WORD_W-1:0] word_dat_o
);

  logic [1:0]             cnt_q,   cnt_d;
  logic [23:0]            shift_q, shift_d;
  logic [IMEM_WORD_W-1:0] word_q,  word_d;
  logic                   vld_q,   vld_d;

  // The first three bytes of a word wait in shift_q; the 4th completes word_q,
  // which then holds steady until the next word completes.
  always_comb begin
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    word_d      = word_q;
    vld_d       = 1'b0;
    word_last_o = byte_acc_i && (cnt_q == 2'd3);
    if (clr_i) begin
      cnt_d   = 2'd0;
      shift_d = '0;
    end else if (byte_acc_i) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = {byte_dat_i, shift_q[23:8]};
      if (cnt_q == 2'd3) begin
        word_d = {byte_dat_i, shift_q};
        vld_d  = 1'b1;
      end
    end
  end

  // Assembler state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 2'd0;
      shift_q <= '0;
      word_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      vld_q   <= vld_d;
    end
  end

  assign word_vld_o = vld_q;
  assign word_dat_o = word_q;

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instr_mem and gates core reset.
// Latency: one instr_mem write one cycle after each word's 4th byte; status one cycle after the checksum byte.
// Backpressure: byte_rdy_o is high only while a byte is expected; optional idle timeout via IMEM_LOADER_TIMEOUT_EN.
module imem_loader
  import mips_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR        = 32'h0,
  parameter int          IMEM_DEPTH_WORDS = IMEM_DEPTH_WORDS_DFLT,
  parameter int          TIMEOUT_CYCLES   = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic                   byte_vld_i,
  input  logic [IMEM_BYTE_W-1:0] byte_data_i,
  output logic                   byte_rdy_o,
  output logic                   wr_en_imem_o,
  output logic [31:0]            wr_addr_imem_o,
  output logic [IMEM_WORD_W-1:0] wr_instr_imem_o,
  output logic                   core_reset_o,
  output logic                   done_o,
  output logic                   err_o
);

  localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH_WORDS);

  // Parameter sanity at elaboration time.
  if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
    $error("imem_loader: BASE_ADDR must be 4-byte aligned");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("imem_loader: TIMEOUT_CYCLES must be at least 1");
  end

  ldr_state_e        state_q,  state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [15:0]       n_q,      n_d;
  logic [15:0]       widx_q,   widx_d;
  logic [7:0]        csum_q,   csum_d;
  logic [31:0]       addr_q,   addr_d;
  logic              clr_asm;
  logic              byte_acc;
  logic              word_last;
  logic [15:0]       len_word;

  assign byte_rdy_o = ldr_takes_bytes(state_q);
  assign byte_acc   = byte_vld_i && byte_rdy_o;
  assign len_word   = {byte_data_i, len_lo_q};

`ifdef IMEM_LOADER_TIMEOUT_EN
  localparam int              TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYCLES);
  logic [TO_W-1:0] idle_q, idle_d;
`endif

  // Next-state logic: header parsing, word addressing, checksum and status.
  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    n_d      = n_q;
    widx_d   = widx_q;
    csum_d   = csum_q;
    addr_d   = addr_q;
    clr_asm  = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_i) begin
          state_d = ST_LEN0;
          widx_d  = '0;
          csum_d  = '0;
          clr_asm = 1'b1;
        end
      end
      ST_LEN0: begin
        if (byte_acc) begin
          len_lo_d = byte_data_i;
          state_d  = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (byte_acc) begin
          n_d = len_word;
          if (len_word == 16'd0) begin
            state_d = ST_CSUM;
          end else if ({16'd0, len_word} > DEPTH_W) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (byte_acc) begin
          csum_d = csum_q ^ byte_data_i;
          if (word_last) begin
            // Address is set on the same edge the word completes, so it lines up with wr_en.
            addr_d = BASE_ADDR + {14'd0, widx_q, 2'b00};
            widx_d = widx_q + 16'd1;
            if ((widx_q + 16'd1) == n_q) begin
              state_d = ST_CSUM;
            end
          end
        end
      end
      ST_CSUM: begin
        if (byte_acc) begin
          state_d = (byte_data_i == csum_q) ? ST_DONE : ST_ERR;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef IMEM_LOADER_TIMEOUT_EN
    idle_d = '0;
    if (byte_rdy_o && !byte_acc) begin
      idle_d = (idle_q == TO_LIM) ? idle_q : idle_q + TO_W'(1);
    end
    if (byte_rdy_o && (idle_q == TO_LIM)) begin
      state_d = ST_ERR;
    end
    if (!ldr_takes_bytes(state_d)) begin
      idle_d = '0;
    end
`endif
  end

  // Loader state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      len_lo_q <= '0;
      n_q      <= '0;
      widx_q   <= '0;
      csum_q   <= '0;
      addr_q   <= BASE_ADDR;
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      n_q      <= n_d;
      widx_q   <= widx_d;
      csum_q   <= csum_d;
      addr_q   <= addr_d;
    end
  end

`ifdef IMEM_LOADER_TIMEOUT_EN
  // Idle-cycle counter between accepted bytes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end
`endif

  loader_word_asm u_word_asm (
    .clk         (clk),
    .rst         (reset),
    .clr_i       (clr_asm),
    .byte_acc_i  (byte_acc && (state_q == ST_DATA)),
    .byte_dat_i  (byte_data_i),
    .word_last_o (word_last),
    .word_vld_o  (wr_en_imem_o),
    .word_dat_o  (wr_instr_imem_o)
  );

  assign wr_addr_imem_o = addr_q;
  assign done_o         = (state_q == ST_DONE);
  assign err_o          = (state_q == ST_ERR);
  assign core_reset_o   = (state_q != ST_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed stream scenarios plus randomized loads vs a stream model.
// Latency: writes and status are sampled a cycle after the bytes that cause them.
// Backpressure: byte_vld_i is driven with random gaps and held until byte_rdy_o accepts.
module tb_imem_loader;

  localparam logic [31:0] BASE  = 32'h0;
  localparam int          DEPTH = 1024;
`ifdef IMEM_LOADER_TIMEOUT_EN
  localparam int          TO    = 16;
`else
  localparam int          TO    = 4096;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        byte_vld_i = 1'b0;
  logic [7:0]  byte_data_i = 8'h00;
  logic        byte_rdy_o, wr_en_imem_o, core_reset_o, done_o, err_o;
  logic [31:0] wr_addr_imem_o, wr_instr_imem_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] cap_addr[$], cap_data[$];
  logic [7:0]  stim[$];
  logic [31:0] exp_addr[$], exp_data[$];
  logic        exp_done, exp_err;
  int          exp_consume;

  imem_loader #(.BASE_ADDR(BASE), .IMEM_DEPTH_WORDS(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(rst), .start_i(start_i), .byte_vld_i(byte_vld_i), .byte_data_i(byte_data_i),
    .byte_rdy_o(byte_rdy_o), .wr_en_imem_o(wr_en_imem_o), .wr_addr_imem_o(wr_addr_imem_o),
    .wr_instr_imem_o(wr_instr_imem_o), .core_reset_o(core_reset_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // Record every instr_mem write.
  always @(negedge clk) begin
    if (wr_en_imem_o) begin
      cap_addr.push_back(wr_addr_imem_o);
      cap_data.push_back(wr_instr_imem_o);
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1; tick(); start_i = 1'b0;
  endtask

  // Present one byte and hold it until the loader accepts it (bounded).
  task automatic send_byte(input logic [7:0] b);
    logic r; logic ok;
    ok = 1'b0;
    byte_vld_i = 1'b1; byte_data_i = b;
    for (int k = 0; k < 64 && !ok; k++) begin
      r = byte_rdy_o;
      tick();
      if (r) ok = 1'b1;
    end
    byte_vld_i = 1'b0; byte_data_i = $urandom_range(255, 0);
    checks++;
    if (!ok) begin errors++; $display("FAIL handshake: byte %h not accepted within 64 cycles", b); end
  endtask

  // Stream model: decode the stream directly from its format rules.
  task automatic model();
    int n; logic [7:0] x;
    exp_addr.delete(); exp_data.delete();
    n = int'({stim[1], stim[0]});
    if (n > DEPTH) begin
      exp_err = 1'b1; exp_done = 1'b0; exp_consume = 2;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      exp_addr.push_back(BASE + 32'(4 * i));
      exp_data.push_back({stim[2+4*i+3], stim[2+4*i+2], stim[2+4*i+1], stim[2+4*i]});
      for (int j = 0; j < 4; j++) x = x ^ stim[2+4*i+j];
    end
    exp_consume = 2 + 4 * n + 1;
    exp_done = (stim[2+4*n] == x);
    exp_err  = !exp_done;
  endtask

  // Build a stream of n random words with a correct or corrupted checksum.
  task automatic build_stim(input int n, input bit good);
    logic [7:0] x; logic [7:0] b;
    stim.delete(); x = 8'h00;
    stim.push_back(8'(n)); stim.push_back(8'(n >> 8));
    for (int i = 0; i < 4 * n; i++) begin
      b = $urandom_range(255, 0); stim.push_back(b); x = x ^ b;
    end
    stim.push_back(good ? x : x ^ 8'($urandom_range(255, 1)));
  endtask

  task automatic drive(input int max_gap);
    pulse_start();
    for (int i = 0; i < exp_consume; i++) begin
      repeat ($urandom_range(max_gap, 0)) tick();
      send_byte(stim[i]);
    end
  endtask

  task automatic test_reset();
    #3;
    checks++; if (byte_rdy_o !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b want 0", byte_rdy_o); end
    checks++; if (wr_en_imem_o !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b want 0", wr_en_imem_o); end
    checks++; if (core_reset_o !== 1'b1) begin errors++; $display("FAIL reset_core_reset: got %b want 1", core_reset_o); end
    checks++; if (done_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL reset_status: done %b err %b want 0 0", done_o, err_o); end
    checks++; if (wr_addr_imem_o !== BASE) begin errors++; $display("FAIL reset_addr: got %h want %h", wr_addr_imem_o, BASE); end
    checks++; if (wr_instr_imem_o !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", wr_instr_imem_o); end
    repeat (2) tick();
    rst = 1'b0;
    byte_vld_i = 1'b1; repeat (3) tick(); byte_vld_i = 1'b0;
    checks++; if (byte_rdy_o !== 1'b0 || core_reset_o !== 1'b1) begin errors++; $display("FAIL idle_hold: rdy %b core_reset %b want 0 1", byte_rdy_o, core_reset_o); end
  endtask

  // Two-word image; XOR of the eight data bytes is 0x09, so 0x09 is the good checksum and 0x08 is bad.
  task automatic test_two_word(input logic [7:0] csum, input bit good);
    stim = '{8'h02, 8'h00, 8'h0C, 8'h00, 8'h08, 8'h20, 8'h04, 8'h00, 8'h09, 8'h20, csum};
    cap_addr.delete(); cap_data.delete();
    pulse_start();
    for (int i = 0; i < stim.size(); i++) send_byte(stim[i]);
    checks++; if (done_o !== good || err_o !== !good) begin errors++; $display("FAIL two_word_status: done %b err %b want %b %b", done_o, err_o, good, !good); end
    checks++; if (core_reset_o !== !good) begin errors++; $display("FAIL two_word_core_reset: got %b want %b", core_reset_o, !good); end
    sample();
    checks++;
    if (cap_addr.size() != 2) begin errors++; $display("FAIL two_word_count: got %0d writes want 2", cap_addr.size()); end
    else begin
      if (cap_addr[0] !== 32'h0 || cap_data[0] !== 32'h2008000C) begin errors++; $display("FAIL two_word_w0: got %h@%h want 2008000c@0", cap_data[0], cap_addr[0]); end
      checks++;
      if (cap_addr[1] !== 32'h4 || cap_data[1] !== 32'h20090004) begin errors++; $display("FAIL two_word_w1: got %h@%h want 20090004@4", cap_data[1], cap_addr[1]); end
    end
    tick();
  endtask

  task automatic test_oversize();
    stim = '{8'h01, 8'h04};
    cap_addr.delete(); cap_data.delete();
    pulse_start();
    send_byte(stim[0]); send_byte(stim[1]);
    checks++; if (err_o !== 1'b1 || byte_rdy_o !== 1'b0) begin errors++; $display("FAIL oversize_state: err %b rdy %b want 1 0", err_o, byte_rdy_o); end
    byte_vld_i = 1'b1; repeat (6) tick(); byte_vld_i = 1'b0;
    sample();
    checks++; if (cap_addr.size() != 0) begin errors++; $display("FAIL oversize_writes: got %0d want 0", cap_addr.size()); end
    checks++; if (core_reset_o !== 1'b1 || done_o !== 1'b0) begin errors++; $display("FAIL oversize_core: core_reset %b done %b want 1 0", core_reset_o, done_o); end
    tick();
  endtask

  task automatic test_zero_then_one();
    logic [31:0] w;
    stim = '{8'h00, 8'h00, 8'h00};
    cap_addr.delete(); cap_data.delete();
    pulse_start();
    for (int i = 0; i < 3; i++) send_byte(stim[i]);
    sample();
    checks++; if (done_o !== 1'b1 || err_o !== 1'b0 || cap_addr.size() != 0) begin errors++; $display("FAIL zero_len: done %b err %b writes %0d want 1 0 0", done_o, err_o, cap_addr.size()); end
    tick();
    w = $urandom();
    stim = '{8'h01, 8'h00, w[7:0], w[15:8], w[23:16], w[31:24], w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24]};
    pulse_start();
    checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL restart_clear: done %b want 0", done_o); end
    for (int i = 0; i < stim.size(); i++) send_byte(stim[i]);
    sample();
    checks++;
    if (cap_addr.size() != 1 || cap_addr[0] !== BASE || cap_data[0] !== w) begin
      errors++; $display("FAIL one_word: writes %0d first %h@%h want 1 %h@%h", cap_addr.size(), cap_data.size() ? cap_data[0] : 32'hx, cap_addr.size() ? cap_addr[0] : 32'hx, w, BASE);
    end
    checks++; if (done_o !== 1'b1 || core_reset_o !== 1'b0) begin errors++; $display("FAIL one_word_done: done %b core_reset %b want 1 0", done_o, core_reset_o); end
    tick();
  endtask

  task automatic test_backpressure_abort();
    stim = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88};
    cap_addr.delete(); cap_data.delete();
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(stim[i]);
    pulse_start();                      // ignored mid-load
    send_byte(stim[4]);
    tick(); tick();                     // valid low for two cycles mid-word
    send_byte(stim[5]);
    send_byte(stim[6]);                 // fifth data byte
    sample();
    checks++;
    if (cap_addr.size() != 1 || cap_data[0] !== 32'h44332211 || cap_addr[0] !== BASE) begin
      errors++; $display("FAIL bp_word0: writes %0d want 1 of 44332211@%h", cap_addr.size(), BASE);
    end
    rst = 1'b1; #1;
    checks++; if (byte_rdy_o !== 1'b0 || wr_en_imem_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0) begin errors++; $display("FAIL abort_outputs: rdy %b wr %b done %b err %b want 0 0 0 0", byte_rdy_o, wr_en_imem_o, done_o, err_o); end
    checks++; if (core_reset_o !== 1'b1 || wr_addr_imem_o !== BASE || wr_instr_imem_o !== 32'h0) begin errors++; $display("FAIL abort_regs: core_reset %b addr %h instr %h want 1 %h 0", core_reset_o, wr_addr_imem_o, wr_instr_imem_o, BASE); end
    tick(); tick(); rst = 1'b0;
    byte_vld_i = 1'b1; repeat (8) tick(); byte_vld_i = 1'b0;
    sample();
    checks++; if (cap_addr.size() != 1 || byte_rdy_o !== 1'b0) begin errors++; $display("FAIL abort_after: writes %0d rdy %b want 1 0", cap_addr.size(), byte_rdy_o); end
    tick();
  endtask

  task automatic test_stall();
    stim = '{8'h02, 8'h00, 8'h0C, 8'h00, 8'h08, 8'h20, 8'h04, 8'h00, 8'h09, 8'h20, 8'h09};
    cap_addr.delete(); cap_data.delete();
    pulse_start();
    for (int i = 0; i < 4; i++) send_byte(stim[i]);
    repeat (20) tick();
`ifdef IMEM_LOADER_TIMEOUT_EN
    checks++; if (err_o !== 1'b1 || byte_rdy_o !== 1'b0 || core_reset_o !== 1'b1) begin errors++; $display("FAIL timeout: err %b rdy %b core_reset %b want 1 0 1", err_o, byte_rdy_o, core_reset_o); end
`else
    checks++; if (byte_rdy_o !== 1'b1 || err_o !== 1'b0) begin errors++; $display("FAIL stall_wait: rdy %b err %b want 1 0", byte_rdy_o, err_o); end
    for (int i = 4; i < stim.size(); i++) send_byte(stim[i]);
    sample();
    checks++; if (done_o !== 1'b1 || cap_addr.size() != 2) begin errors++; $display("FAIL stall_resume: done %b writes %0d want 1 2", done_o, cap_addr.size()); end
`endif
    tick();
  endtask

  // Randomized loads: full-depth image, oversize image, then short random images.
  task automatic test_random_loads();
    int n; bit good;
    for (int it = 0; it < 10; it++) begin
      if (it == 0) n = DEPTH;
      else if (it == 1) n = DEPTH + 1 + $urandom_range(50, 0);
      else n = $urandom_range(6, 0);
      good = (it == 0) ? 1'b1 : 1'($urandom_range(3, 0) != 0);
      build_stim(n, good);
      model();
      cap_addr.delete(); cap_data.delete();
      drive((it == 0) ? 0 : 2);
      sample();
      checks++;
      if (cap_addr.size() != exp_addr.size()) begin
        errors++; $display("FAIL rand%0d_count: got %0d writes want %0d", it, cap_addr.size(), exp_addr.size());
      end else begin
        for (int i = 0; i < exp_addr.size(); i++) begin
          checks++;
          if (cap_addr[i] !== exp_addr[i] || cap_data[i] !== exp_data[i]) begin
            errors++; $display("FAIL rand%0d_w%0d: got %h@%h want %h@%h", it, i, cap_data[i], cap_addr[i], exp_data[i], exp_addr[i]);
          end
        end
      end
      checks++;
      if (done_o !== exp_done || err_o !== exp_err || core_reset_o !== !exp_done || byte_rdy_o !== 1'b0) begin
        errors++; $display("FAIL rand%0d_status: done %b err %b core_reset %b rdy %b want %b %b %b 0", it, done_o, err_o, core_reset_o, byte_rdy_o, exp_done, exp_err, !exp_done);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_two_word(8'h09, 1'b1);
    test_two_word(8'h08, 1'b0);
    test_oversize();
    test_zero_then_one();
    test_backpressure_abort();
    test_stall();
    test_random_loads();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
